// File: rtl/hdlc_line_monitor.sv
// HDLC line monitor: watches per-channel Rx/Tx bit streams and controller detect
// outputs, latches rule violations per channel and counts them in a saturating counter.
module hdlc_line_monitor #(
   parameter int NUM_CH    = 1,
   parameter int FLAG_LAT  = 2,
   parameter int ABORT_LAT = 2,
   parameter int IDLE_LEN  = 8,
   parameter int CNT_W     = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Mon_En,
   input  logic                  ErrClr,
   input  logic [NUM_CH-1:0]     Rx,
   input  logic [NUM_CH-1:0]     Rx_FlagDetect,
   input  logic [NUM_CH-1:0]     Rx_AbortDetect,
   input  logic [NUM_CH-1:0]     Tx,
   input  logic [NUM_CH-1:0]     Tx_ValidFrame,
   output logic [4*NUM_CH-1:0]   Err_Sticky,
   output logic [NUM_CH-1:0]     Err_Pulse,
   output logic [CNT_W-1:0]      ErrCnt
);

   localparam logic [1:0] Z_IDLE = 2'd0;
   localparam logic [1:0] Z_HUNT = 2'd1;
   localparam logic [1:0] Z_DATA = 2'd2;

   localparam int IW = $clog2(IDLE_LEN + 1);
   localparam int PW = $clog2(4 * NUM_CH + 1);
   localparam int SW = CNT_W + PW;
   localparam logic [SW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};
   localparam logic [IW-1:0] IDLE_SAT = IW'(IDLE_LEN);

   logic [4*NUM_CH-1:0] viol;
   logic [NUM_CH-1:0]   pulse_next;

   genvar ch;
   generate
      for (ch = 0; ch < NUM_CH; ch++) begin : gen_ch
         // The oldest history bit never reaches a window, so seven bits are kept.
         logic [6:0]           rx_hist;
         logic [6:0]           tx_hist;
         logic [7:0]           rx_win;
         logic [7:0]           tx_win;
         logic [FLAG_LAT-1:0]  flag_line;
         logic [ABORT_LAT-1:0] abort_line;
         logic                 abort_prev;
         logic [1:0]           z_state;
         logic [2:0]           ones;
         logic [IW-1:0]        idle_cnt;
         logic                 flag_viol;
         logic                 abort_viol;
         logic                 zero_viol;
         logic                 idle_viol;

         assign rx_win = {rx_hist, Rx[ch]};
         assign tx_win = {tx_hist, Tx[ch]};

         assign flag_viol  = Mon_En & flag_line[FLAG_LAT-1] & ~Rx_FlagDetect[ch];
         assign abort_viol = Mon_En & abort_line[ABORT_LAT-1]
                             & ~(Rx_AbortDetect[ch] & ~abort_prev);
         assign zero_viol  = Mon_En & Tx_ValidFrame[ch] & (z_state == Z_DATA)
                             & (ones == 3'd5) & Tx[ch];
         assign idle_viol  = Mon_En & ~Tx_ValidFrame[ch] & (idle_cnt == IDLE_SAT) & ~Tx[ch];

         assign viol[ch*4 +: 4] = {idle_viol, zero_viol, abort_viol, flag_viol};
         assign pulse_next[ch]  = flag_viol | abort_viol | zero_viol | idle_viol;

         always_ff @(posedge Clk) begin
            if (Rst) begin
               rx_hist    <= 7'h7F;
               tx_hist    <= 7'h7F;
               abort_prev <= 1'b0;
            end else begin
               rx_hist    <= rx_win[6:0];
               tx_hist    <= tx_win[6:0];
               abort_prev <= Rx_AbortDetect[ch];
            end
         end

         // Token lines are plain shift registers so overlapping flags stay independent.
         always_ff @(posedge Clk) begin
            if (Rst || !Mon_En) begin
               flag_line  <= '0;
               abort_line <= '0;
            end else begin
               flag_line  <= FLAG_LAT'({flag_line, (rx_win == 8'h7E)});
               abort_line <= ABORT_LAT'({abort_line, (rx_win == 8'h7F)});
            end
         end

         always_ff @(posedge Clk) begin
            if (Rst || !Mon_En || !Tx_ValidFrame[ch]) begin
               z_state <= Z_IDLE;
               ones    <= 3'd0;
            end else begin
               case (z_state)
                  Z_IDLE: z_state <= Z_HUNT;
                  Z_HUNT: begin
                     if (tx_win == 8'h7E) begin
                        z_state <= Z_DATA;
                        ones    <= 3'd0;
                     end
                  end
                  Z_DATA: begin
                     if (Tx[ch])
                        ones <= (ones == 3'd5) ? 3'd0 : ones + 3'd1;
                     else
                        ones <= 3'd0;
                  end
                  default: begin
                     z_state <= Z_IDLE;
                     ones    <= 3'd0;
                  end
               endcase
            end
         end

         always_ff @(posedge Clk) begin
            if (Rst || !Mon_En || Tx_ValidFrame[ch])
               idle_cnt <= '0;
            else if (idle_cnt != IDLE_SAT)
               idle_cnt <= idle_cnt + IW'(1);
         end
      end
   endgenerate

   logic [PW-1:0] pop;
   logic [SW-1:0] cnt_sum;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      pop = '0;
      for (int i = 0; i < 4 * NUM_CH; i++)
         pop = pop + PW'(viol[i]);
   end

   // A clear restarts the count from this edge's violations rather than zero.
   always_comb begin
      cnt_sum = ErrClr ? SW'(pop) : (SW'(ErrCnt) + SW'(pop));
      cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Err_Sticky <= '0;
         Err_Pulse  <= '0;
         ErrCnt     <= '0;
      end else begin
         Err_Sticky <= ErrClr ? viol : (Err_Sticky | viol);
         Err_Pulse  <= pulse_next;
         ErrCnt     <= cnt_next;
      end
   end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Bench for hdlc_line_monitor with two channels and a 2-bit counter: table-driven
// vectors plus hand-written Tx sequences, checked through an expected-result queue.
module tb_hdlc_line_monitor;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Mon_En;
   logic       ErrClr;
   logic [1:0] Rx;
   logic [1:0] Rx_FlagDetect;
   logic [1:0] Rx_AbortDetect;
   logic [1:0] Tx;
   logic [1:0] Tx_ValidFrame;
   logic [7:0] Err_Sticky;
   logic [1:0] Err_Pulse;
   logic [1:0] ErrCnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       mon;
      logic       clr;
      logic [1:0] rx;
      logic [1:0] fd;
      logic [1:0] ad;
      logic [1:0] tx;
      logic [1:0] tv;
      logic       chk;
      logic [7:0] sticky;
      logic [1:0] pulse;
      logic [1:0] cnt;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] sticky;
      logic [1:0] pulse;
      logic [1:0] cnt;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t expq[$];

   hdlc_line_monitor #(
      .NUM_CH(2), .FLAG_LAT(2), .ABORT_LAT(2), .IDLE_LEN(8), .CNT_W(2)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Mon_En(Mon_En), .ErrClr(ErrClr),
      .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
      .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
      .Err_Sticky(Err_Sticky), .Err_Pulse(Err_Pulse), .ErrCnt(ErrCnt)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t mkRow(input logic mon, input logic clr, input logic [1:0] rx,
                                  input logic [1:0] fd, input logic [1:0] ad,
                                  input logic [1:0] tx, input logic [1:0] tv,
                                  input logic chk, input logic [7:0] s,
                                  input logic [1:0] p, input logic [1:0] c, input string n);
      vec_t v;
      v.mon = mon; v.clr = clr; v.rx = rx; v.fd = fd; v.ad = ad; v.tx = tx; v.tv = tv;
      v.chk = chk; v.sticky = s; v.pulse = p; v.cnt = c; v.name = n;
      return v;
   endfunction

   task automatic checkOutput();
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (Err_Sticky !== e.sticky) begin
         errors++;
         $display("[TB] FAIL %s sticky: got %h expected %h", e.name, Err_Sticky, e.sticky);
      end
      checks++;
      if (Err_Pulse !== e.pulse) begin
         errors++;
         $display("[TB] FAIL %s pulse: got %b expected %b", e.name, Err_Pulse, e.pulse);
      end
      checks++;
      if (ErrCnt !== e.cnt) begin
         errors++;
         $display("[TB] FAIL %s count: got %0d expected %0d", e.name, ErrCnt, e.cnt);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      Mon_En = v.mon; ErrClr = v.clr; Rx = v.rx; Rx_FlagDetect = v.fd;
      Rx_AbortDetect = v.ad; Tx = v.tx; Tx_ValidFrame = v.tv;
      if (v.chk) begin
         e.sticky = v.sticky; e.pulse = v.pulse; e.cnt = v.cnt; e.name = v.name;
         expq.push_back(e);
      end
      @(posedge Clk);
      #1;
      if (v.chk) checkOutput();
   endtask

   task automatic addRow(input logic clr, input logic [1:0] fd, input logic [1:0] ad,
                         input logic [1:0] tx, input logic chk, input logic [7:0] s,
                         input logic [1:0] p, input logic [1:0] c, input string n);
      vecs.push_back(mkRow(1'b1, clr, 2'b11, fd, ad, tx, 2'b00, chk, s, p, c, n));
   endtask

   task automatic addBits(input logic [1:0] mask, input logic [7:0] pat);
      logic [7:0] p;
      p = pat;
      for (int i = 0; i < 8; i++)
         vecs.push_back(mkRow(1'b1, 1'b0, p[7-i] ? 2'b11 : ~mask, 2'b00, 2'b00, 2'b11,
                              2'b00, 1'b0, 8'h00, 2'b00, 2'b00, ""));
   endtask

   task automatic addQuiesce();
      for (int i = 0; i < 10; i++)
         vecs.push_back(mkRow(1'b0, i == 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, i == 9,
                              8'h00, 2'b00, 2'b00, "quiesce"));
   endtask

   task automatic doQuiesce();
      for (int i = 0; i < 10; i++)
         applyStimulus(mkRow(1'b0, i == 0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, i == 9,
                             8'h00, 2'b00, 2'b00, "quiesce_hand"));
   endtask

   task automatic txRow(input logic t, input logic v, input logic chk, input logic [7:0] s,
                        input logic [1:0] p, input logic [1:0] c, input string n);
      applyStimulus(mkRow(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, {1'b1, t}, {1'b0, v}, chk,
                          s, p, c, n));
   endtask

   initial begin
      logic [7:0]  flag;
      logic [10:0] bad_data;
      logic [16:0] good_data;
      flag      = 8'h7E;
      bad_data  = 11'b11111_0_11111;
      good_data = 17'b11111_0_11111_0_11111;

      // Flag detected on time, then missed detect.
      addBits(2'b01, 8'h7E);
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 2'd0, "");
      addRow(1'b0, 2'b01, 2'b00, 2'b11, 1'b1, 8'h00, 2'b00, 2'd0, "flag_ok_det");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h00, 2'b00, 2'd0, "flag_ok_after");
      addQuiesce();
      addBits(2'b01, 8'h7E);
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 2'd0, "");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h01, 2'b01, 2'd1, "flag_miss");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h01, 2'b00, 2'd1, "flag_miss_hold");
      addQuiesce();
      // Abort detect rising on time, then one cycle late.
      addBits(2'b01, 8'h7F);
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 2'd0, "");
      addRow(1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 8'h00, 2'b00, 2'd0, "abort_ok");
      addRow(1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 8'h00, 2'b00, 2'd0, "abort_ok_after");
      addQuiesce();
      addBits(2'b01, 8'h7F);
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 2'd0, "");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h02, 2'b01, 2'd1, "abort_late");
      addRow(1'b0, 2'b00, 2'b01, 2'b11, 1'b1, 8'h02, 2'b00, 2'd1, "abort_late_hold");
      addQuiesce();
      // Both channels miss a flag, then idle violations drive the counter into saturation.
      addBits(2'b11, 8'h7E);
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 8'h00, 2'b00, 2'd0, "");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h11, 2'b11, 2'd2, "dual_flag_miss");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h11, 2'b00, 2'd2, "dual_flag_hold");
      addRow(1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 8'h19, 2'b01, 2'd3, "sat1");
      addRow(1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 8'h19, 2'b01, 2'd3, "sat2");
      addRow(1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 8'h19, 2'b01, 2'd3, "sat3");
      addRow(1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 8'h80, 2'b10, 2'd1, "clr_new");
      addRow(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 8'h80, 2'b00, 2'd1, "clr_hold");
      addQuiesce();

      Rst = 1'b1;
      applyStimulus(mkRow(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0,
                          8'h00, 2'b00, 2'd0, ""));
      applyStimulus(mkRow(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1,
                          8'h00, 2'b00, 2'd0, "reset_state"));
      Rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i]);

      // Unstuffed frame: one violation on the sixth consecutive 1.
      for (int i = 0; i < 8; i++)
         txRow(flag[7-i], 1'b1, 1'b0, 8'h00, 2'b00, 2'd0, "");
      for (int i = 0; i < 11; i++)
         txRow(bad_data[10-i], 1'b1, i == 10, 8'h00, 2'b00, 2'd0, "zi_pre");
      txRow(1'b1, 1'b1, 1'b1, 8'h04, 2'b01, 2'd1, "zi_sixth_one");
      txRow(1'b1, 1'b1, 1'b1, 8'h04, 2'b00, 2'd1, "zi_once");
      txRow(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, "");
      doQuiesce();

      // Correctly stuffed frame.
      for (int i = 0; i < 8; i++)
         txRow(flag[7-i], 1'b1, 1'b0, 8'h00, 2'b00, 2'd0, "");
      for (int i = 0; i < 17; i++)
         txRow(good_data[16-i], 1'b1, i == 16, 8'h00, 2'b00, 2'd0, "zi_stuffed");
      txRow(1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 2'd0, "zi_stuffed_end");
      doQuiesce();

      // Idle pattern: a 0 on the 7th idle cycle is allowed, after the 8th it is not.
      for (int i = 0; i < 6; i++)
         txRow(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, "");
      txRow(1'b0, 1'b0, 1'b1, 8'h00, 2'b00, 2'd0, "idle_7th");
      txRow(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0, "");
      txRow(1'b0, 1'b0, 1'b1, 8'h08, 2'b01, 2'd1, "idle_v1");
      txRow(1'b0, 1'b0, 1'b1, 8'h08, 2'b01, 2'd2, "idle_v2");
      txRow(1'b0, 1'b0, 1'b1, 8'h08, 2'b01, 2'd3, "idle_v3");
      txRow(1'b1, 1'b0, 1'b1, 8'h08, 2'b00, 2'd3, "idle_hold");

      // Reset while a flag token is pending discards it.
      for (int i = 0; i < 8; i++)
         applyStimulus(mkRow(1'b1, 1'b0, flag[7-i] ? 2'b11 : 2'b10, 2'b00, 2'b00, 2'b11,
                             2'b00, 1'b0, 8'h00, 2'b00, 2'd0, ""));
      Rst = 1'b1;
      applyStimulus(mkRow(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1,
                          8'h00, 2'b00, 2'd0, "rst_outputs"));
      Rst = 1'b0;
      for (int i = 0; i < 3; i++)
         applyStimulus(mkRow(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1,
                             8'h00, 2'b00, 2'd0, "rst_no_token"));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/hdlc_line_monitor.md
# hdlc_line_monitor

Synthesisable, parametrised HDLC line monitor that runs in silicon alongside one or more HDLC channels. It watches the serial Rx/Tx bit streams and the controller's detect/framing outputs, and checks four rules: flag-detect latency, abort-detect latency, Tx zero insertion and the Tx idle pattern. Violations are latched per channel per rule, pulsed, and counted in a saturating error counter. The block sits beside the HDLC top level and is read by the host or by the test bench.

## Interface
- NUM_CH, 1, number of monitored channels (1..8)
- FLAG_LAT, 2, cycles from last flag bit sampled to required Rx_FlagDetect (≥1)
- ABORT_LAT, 2, cycles from last abort bit sampled to required rise of Rx_AbortDetect (≥1)
- IDLE_LEN, 8, consecutive cycles of Tx_ValidFrame low after which Tx must be 1 (≥8)
- CNT_W, 16, error counter width
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  reset, synchronous, active-high
- Mon_En  in  1  1 = checks active; 0 = checks suppressed, delay lines flushed, history still shifts
- ErrClr  in  1  clears Err_Sticky and ErrCnt
- Rx  in  NUM_CH  serial receive bit per channel
- Rx_FlagDetect  in  NUM_CH  controller flag-detect per channel
- Rx_AbortDetect  in  NUM_CH  controller abort-detect per channel
- Tx  in  NUM_CH  serial transmit bit per channel
- Tx_ValidFrame  in  NUM_CH  transmitter frame-active per channel
- Err_Sticky  out  4*NUM_CH  sticky violations; bit ch*4+k, k: 0 flag, 1 abort, 2 zero-insertion, 3 idle
- Err_Pulse  out  NUM_CH  registered; 1 for one cycle when any rule on the channel is violated
- ErrCnt  out  CNT_W  saturating count of violation events, all channels and rules

## Operation
- Per channel: rx_hist[7:0], tx_hist[7:0]. Each edge: hist <= {hist[6:0], bit}. Bit [7] is the oldest.
- The "window" is {hist[6:0], current bit}, evaluated on the edge where the current bit is sampled.
- Flag rule: window == 8'b0111_1110 pushes a token into a FLAG_LAT-deep shift line. When the token reaches the end, the rule is violated if Rx_FlagDetect == 0 on that edge.
- Abort rule: window == 8'b0111_1111 pushes a token into an ABORT_LAT-deep line. At the end, the rule is violated unless Rx_AbortDetect == 1 now and Rx_AbortDetect == 0 on the previous edge. A run of further 1s does not re-trigger, because the pattern needs the leading 0.
- Zero-insertion FSM per channel, states Z_IDLE, Z_HUNT, Z_DATA:
  - Z_IDLE: Tx_ValidFrame=1 → Z_HUNT.
  - Z_HUNT: Tx window == 8'h7E → Z_DATA with ones=0.
  - Z_DATA: Tx=1 → ones++; Tx=0 → ones=0. If ones==5 and Tx==1, the rule is violated and ones is set to 0.
  - Any state: Tx_ValidFrame=0 → Z_IDLE, ones=0. Rule for the transmitter: Tx_ValidFrame is low for every bit of the closing flag.
- Idle rule: idle_cnt counts consecutive edges with Tx_ValidFrame=0 and saturates at IDLE_LEN. It resets to 0 when Tx_ValidFrame=1. When idle_cnt==IDLE_LEN and Tx==0, the rule is violated, once per edge.
- Mon_En=0:
  - No violations are generated.
  - Tokens are cleared.
  - FSMs are held in Z_IDLE.
  - idle_cnt is held at 0.
  - History keeps shifting.
- Violation handling:
  - Err_Sticky bit sets on the edge the violation is detected.
  - Err_Pulse[ch] is the OR of that channel's four new violations.
  - ErrCnt adds the popcount of all new violations (0..4*NUM_CH) on that edge and saturates at 2^CNT_W−1 with no wrap.
- ErrClr has priority over accumulated state. On an edge with ErrClr=1: Err_Sticky = new violations only, ErrCnt = popcount of new violations.

## Timing
- Reset values:
  - rx_hist and tx_hist = 8'hFF.
  - All tokens 0.
  - FSM Z_IDLE, ones=0, idle_cnt=0.
  - Err_Sticky=0, Err_Pulse=0, ErrCnt=0.
- Reset mid-operation discards pending tokens; no violation is reported for them.
- Latency: for a flag whose last 0 is sampled at edge t, Rx_FlagDetect is checked at edge t+FLAG_LAT. Err_Sticky and Err_Pulse are visible from t+FLAG_LAT. The same holds for abort with ABORT_LAT.
- Zero-insertion and idle violations are flagged on the same edge as the offending Tx sample.
- Back-to-back flags (shared 0) each produce a token. Token lines are shift registers, so overlapping tokens are independent.
- Channels are fully independent; simultaneous violations on several channels in one cycle all count.

## Test plan
- Rx=…1 0111_1110 1…, Rx_FlagDetect high 2 cycles after the last 0 → no error; the same stimulus with Rx_FlagDetect held low → Err_Sticky[0]=1, one Err_Pulse, ErrCnt=1.
- Rx = 0 then seven 1s, Rx_AbortDetect rising at +2 → no error; rising at +3 → Err_Sticky[1]=1, ErrCnt=1.
- Tx_ValidFrame=1, Tx = flag 7E then 11111 0 11111 1 → exactly one Err_Sticky[2] event, on the sixth 1; a correctly stuffed frame → 0 errors.
- Tx_ValidFrame low for 8 cycles, then Tx=0 for 3 cycles → ErrCnt=3, Err_Sticky[3]=1; Tx=0 on the 7th idle cycle → no error.
- NUM_CH=2, CNT_W=2:
  - Simultaneous flag violations on both channels → ErrCnt=2.
  - Three more violation events → ErrCnt saturates at 3.
  - ErrClr together with one new violation → ErrCnt=1, sticky holds only the new bit.
- Rst asserted while a flag token is pending → no violation after reset; all outputs 0 on the cycle after the reset edge.
